// File: rtl/btn_conditioner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_conditioner_pkg                                          |
// | Description : Shared constants, types and helpers for the push-button      |
// |               conditioner (synchronizer, debouncer, select counter).       |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package btn_conditioner_pkg;

   // 10 ms of stable input at a 100 MHz system clock.
   localparam int DB_CYCLES_100MHZ_10MS = 1000000;
   // Short debounce window that keeps simulations fast.
   localparam int DB_CYCLES_SIM         = 4;
   // Width of the channel select handed to the LED decoder.
   localparam int SEL_W                 = 2;

   typedef logic [SEL_W-1:0] sel_t;

   // Next select value; wraps naturally from the top code back to zero.
   function automatic sel_t sel_next(input sel_t cur);
      return cur + SEL_W'(1);
   endfunction

endpackage : btn_conditioner_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_debounce_ch                                              |
// | Description : One push-button channel: 2-flop synchronizer, stability     |
// |               counter, debounced level register and registered            |
// |               press/release pulses.                                        |
// | Ports       : clk         - system clock, rising edge                      |
// |               rst_n       - asynchronous active-low reset                  |
// |               btn_raw     - raw asynchronous button, active-high           |
// |               btn_db      - debounced level                                |
// |               btn_press   - one-cycle pulse on debounced 0->1              |
// |               btn_release - one-cycle pulse on debounced 1->0              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_debounce_ch #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = $clog2(DB_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_db,
   output logic btn_press,
   output logic btn_release
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             db_q,    db_d;
   logic             press_q, press_d;
   logic             rel_q,   rel_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      cnt_d   = '0;
      db_d    = db_q;

      // Count consecutive cycles of disagreement; any agreement restarts the
      // window, so a glitch shorter than DB_CYCLES leaves no trace.
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            db_d  = ~db_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Pulses are computed from the next level so they are registered on the
      // same edge as the level change and line up with the new btn_db.
      press_d = db_d & ~db_q;
      rel_d   = ~db_d & db_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign btn_db      = db_q;
   assign btn_press   = press_q;
   assign btn_release = rel_q;

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_conditioner                                              |
// | Description : Input stage for the LED select/decoder. Synchronizes and     |
// |               debounces N_BTN raw buttons, emits press/release pulses and  |
// |               advances a 2-bit select on each debounced press of SEL_BTN.  |
// | Ports       : clk         - system clock, rising edge                      |
// |               rst_n       - asynchronous active-low reset                  |
// |               btn_raw     - raw asynchronous buttons, active-high          |
// |               btn_db      - debounced levels (decoder button input)        |
// |               btn_press   - one-cycle pulse per channel on 0->1            |
// |               btn_release - one-cycle pulse per channel on 1->0            |
// |               sel         - channel select (decoder select input)          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int N_BTN     = 4,
   parameter int DB_CYCLES = DB_CYCLES_100MHZ_10MS,   // must be >= 2
   parameter int SEL_BTN   = 3                        // 0..N_BTN-1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [SEL_W-1:0] sel
);

   localparam int CNT_W = $clog2(DB_CYCLES);

   sel_t sel_q, sel_d;

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_ch
         btn_debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
         ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[i]),
            .btn_db      (btn_db[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
         );
      end
   endgenerate

   // The press pulse is already single-cycle, so holding the button cannot
   // re-advance the select.
   always_comb begin
      sel_d = sel_q;
      if (btn_press[SEL_BTN]) begin
         sel_d = sel_next(sel_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q <= '0;
      end else begin
         sel_q <= sel_d;
      end
   end

   assign sel = sel_q;

endmodule : btn_conditioner
`default_nettype wire
